// File: rtl/channel_pkg.sv
// Definitions shared by both ends of a PE-to-PE channel: the flit framing-bit
// positions and the sender state encoding.
package channel_pkg;

    // Framing-bit positions, counted upward from WORD_WIDTH: flit = {last, first, word}.
    localparam int FLIT_FIRST_BIT = 0;
    localparam int FLIT_LAST_BIT  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } chan_state_e;

endpackage : channel_pkg

// File: rtl/channel_msg_serializer.sv
// Transmit end of a blocking channel. Accepts one NUM_WORDS-word message per handshake
// and writes it one framed flit per cycle, stalling while the channel reports full.
module channel_msg_serializer
    import channel_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int NUM_WORDS  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            initialize,
    input  logic [WORD_WIDTH*NUM_WORDS-1:0] msg_data,
    input  logic                            msg_valid,
    output logic                            msg_ready,
    output logic [WORD_WIDTH+1:0]           ch_data,
    output logic                            ch_valid,
    input  logic                            ch_is_full,
    output logic                            busy
);

    localparam int             IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    chan_state_e                     state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [WORD_WIDTH*NUM_WORDS-1:0] buf_q, buf_d;

    logic clear;
    logic last_word;
    logic accept;

    assign clear     = reset | initialize;
    assign last_word = (idx_q == LAST_IDX);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        busy      = (state_q == ST_SEND);
        ch_valid  = (state_q == ST_SEND) && !ch_is_full;
        msg_ready = !clear &&
                    ((state_q == ST_IDLE) || ((state_q == ST_SEND) && last_word && !ch_is_full));
        accept    = msg_valid && msg_ready;

        ch_data                              = '0;
        ch_data[WORD_WIDTH-1:0]              = buf_q[int'(idx_q)*WORD_WIDTH +: WORD_WIDTH];
        ch_data[WORD_WIDTH + FLIT_FIRST_BIT] = (idx_q == '0);
        ch_data[WORD_WIDTH + FLIT_LAST_BIT]  = last_word;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    buf_d   = msg_data;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!ch_is_full) begin
                    if (!last_word) begin
                        idx_d = idx_q + 1'b1;
                    end else if (accept) begin
                        // Back-to-back: the next message starts with no idle cycle.
                        buf_d = msg_data;
                        idx_d = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: the message buffer has no reset; it is always loaded before it is read.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule : channel_msg_serializer

// File: tb/tb_channel_msg_serializer.sv
// Directed bench for channel_msg_serializer: a 4-word instance for framing, stalls,
// back-to-back, initialize and reset, plus a 1-word instance for the single-flit case.
module tb_channel_msg_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, initialize;

    logic [31:0] msg_data4;
    logic        msg_valid4, msg_ready4, ch_valid4, ch_is_full4, busy4;
    logic [9:0]  ch_data4;

    logic [7:0]  msg_data1;
    logic        msg_valid1, msg_ready1, ch_valid1, ch_is_full1, busy1;
    logic [9:0]  ch_data1;

    int n_cmp = 0;
    int n_err = 0;
    int writes;

    channel_msg_serializer #(.WORD_WIDTH(8), .NUM_WORDS(4)) u_dut4 (
        .clk(clk), .reset(reset), .initialize(initialize),
        .msg_data(msg_data4), .msg_valid(msg_valid4), .msg_ready(msg_ready4),
        .ch_data(ch_data4), .ch_valid(ch_valid4), .ch_is_full(ch_is_full4), .busy(busy4)
    );

    channel_msg_serializer #(.WORD_WIDTH(8), .NUM_WORDS(1)) u_dut1 (
        .clk(clk), .reset(reset), .initialize(initialize),
        .msg_data(msg_data1), .msg_valid(msg_valid1), .msg_ready(msg_ready1),
        .ch_data(ch_data1), .ch_valid(ch_valid1), .ch_is_full(ch_is_full1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1-2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_flit4(input string tag, input logic [9:0] flit, input logic ready);
        check({tag, " valid"}, 32'(ch_valid4), 32'd1);
        check({tag, " data"}, 32'(ch_data4), 32'(flit));
        check({tag, " ready"}, 32'(msg_ready4), 32'(ready));
    endtask

    logic [9:0] exp2 [8];

    initial begin
        reset       = 1'b1;
        initialize  = 1'b0;
        msg_data4   = '0;
        msg_valid4  = 1'b0;
        ch_is_full4 = 1'b0;
        msg_data1   = '0;
        msg_valid1  = 1'b0;
        ch_is_full1 = 1'b0;
        tick();
        tick();

        // Reset state
        settle();
        check("rst ready", 32'(msg_ready4), 32'd0);
        check("rst valid", 32'(ch_valid4), 32'd0);
        check("rst busy", 32'(busy4), 32'd0);

        // 1: single message, no stall; msg_data changes after accept are ignored
        reset      = 1'b0;
        msg_data4  = 32'hDDCC_BBAA;
        msg_valid4 = 1'b1;
        settle();
        check("t1 idle ready", 32'(msg_ready4), 32'd1);
        check("t1 idle valid", 32'(ch_valid4), 32'd0);
        tick();
        msg_valid4 = 1'b0;
        msg_data4  = 32'h0000_0000;
        settle();
        check_flit4("t1 f0", 10'h1AA, 1'b0);
        check("t1 busy", 32'(busy4), 32'd1);
        tick(); settle(); check_flit4("t1 f1", 10'h0BB, 1'b0);
        tick(); settle(); check_flit4("t1 f2", 10'h0CC, 1'b0);
        tick(); settle(); check_flit4("t1 f3", 10'h2DD, 1'b1);
        tick(); settle();
        check("t1 end busy", 32'(busy4), 32'd0);
        check("t1 end valid", 32'(ch_valid4), 32'd0);

        // 2: back-to-back messages, 8 flits with no gap
        exp2 = '{10'h111, 10'h022, 10'h033, 10'h244, 10'h155, 10'h066, 10'h077, 10'h288};
        msg_data4  = 32'h4433_2211;
        msg_valid4 = 1'b1;
        tick();
        msg_data4 = 32'h8877_6655;
        for (int i = 0; i < 8; i++) begin
            settle();
            check($sformatf("t2 f%0d", i), {21'd0, ch_valid4, ch_data4}, {21'd0, 1'b1, exp2[i]});
            tick();
            if (i == 3) msg_valid4 = 1'b0;
        end
        settle();
        check("t2 end busy", 32'(busy4), 32'd0);

        // 3: stall on full while CC is pending; exactly 4 writes
        writes     = 0;
        msg_data4  = 32'hDDCC_BBAA;
        msg_valid4 = 1'b1;
        tick();
        msg_valid4 = 1'b0;
        settle(); check("t3 f0", 32'(ch_data4), 32'h1AA); writes += int'(ch_valid4);
        tick(); settle(); check("t3 f1", 32'(ch_data4), 32'h0BB); writes += int'(ch_valid4);
        tick();
        ch_is_full4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("t3 stall%0d valid", i), 32'(ch_valid4), 32'd0);
            check($sformatf("t3 stall%0d data", i), 32'(ch_data4), 32'h0CC);
            writes += int'(ch_valid4);
            tick();
        end
        ch_is_full4 = 1'b0;
        settle(); check_flit4("t3 f2", 10'h0CC, 1'b0); writes += int'(ch_valid4);
        tick(); settle(); check_flit4("t3 f3", 10'h2DD, 1'b1); writes += int'(ch_valid4);
        tick(); settle(); writes += int'(ch_valid4);
        check("t3 writes", 32'(writes), 32'd4);

        // 4: initialize mid-message, then a fresh message restarts with first=1
        msg_data4  = 32'hDDCC_BBAA;
        msg_valid4 = 1'b1;
        tick();
        msg_valid4 = 1'b0;
        settle(); check("t4 f0", 32'(ch_data4), 32'h1AA);
        tick(); settle(); check("t4 f1", 32'(ch_data4), 32'h0BB);
        tick();
        initialize = 1'b1;
        settle();
        check("t4 init ready", 32'(msg_ready4), 32'd0);
        tick();
        initialize = 1'b0;
        settle();
        check("t4 post valid", 32'(ch_valid4), 32'd0);
        check("t4 post busy", 32'(busy4), 32'd0);
        check("t4 post ready", 32'(msg_ready4), 32'd1);
        msg_data4  = 32'h0D0C_0B0A;
        msg_valid4 = 1'b1;
        tick();
        msg_valid4 = 1'b0;
        settle(); check_flit4("t4 n0", 10'h10A, 1'b0);
        tick(); settle(); check_flit4("t4 n1", 10'h00B, 1'b0);
        tick(); settle(); check_flit4("t4 n2", 10'h00C, 1'b0);
        tick(); settle(); check_flit4("t4 n3", 10'h20D, 1'b1);
        tick();

        // 6: reset held two cycles with a message offered; accept right after release
        reset      = 1'b1;
        msg_data4  = 32'h0403_0201;
        msg_valid4 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check($sformatf("t6 rst%0d ready", i), 32'(msg_ready4), 32'd0);
            check($sformatf("t6 rst%0d valid", i), 32'(ch_valid4), 32'd0);
            tick();
        end
        reset = 1'b0;
        settle();
        check("t6 rel ready", 32'(msg_ready4), 32'd1);
        check("t6 rel valid", 32'(ch_valid4), 32'd0);
        tick();
        msg_valid4 = 1'b0;
        settle(); check_flit4("t6 f0", 10'h101, 1'b0);
        tick(); tick(); tick(); tick();

        // 5: single-word messages, back-to-back
        msg_data1  = 8'h5A;
        msg_valid1 = 1'b1;
        settle();
        check("t5 idle ready", 32'(msg_ready1), 32'd1);
        tick();
        msg_data1 = 8'hA5;
        settle();
        check("t5 f0 valid", 32'(ch_valid1), 32'd1);
        check("t5 f0 data", 32'(ch_data1), 32'h35A);
        check("t5 f0 ready", 32'(msg_ready1), 32'd1);
        tick();
        msg_valid1 = 1'b0;
        settle();
        check("t5 f1 valid", 32'(ch_valid1), 32'd1);
        check("t5 f1 data", 32'(ch_data1), 32'h3A5);
        tick();
        settle();
        check("t5 end valid", 32'(ch_valid1), 32'd0);
        check("t5 end busy", 32'(busy1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_channel_msg_serializer
